fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter BITS_SIZE, default 32, the instruction, address and counter width.
REQ-002 SHALL have parameter MEMORY_SIZE, default 256, the instruction-memory depth in words.
REQ-003 SHALL have parameter RESET_PC, default 0, the first word index fetched after reset.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port imem_addr, output, BITS_SIZE bits, the word index to the combinational instruction memory.
REQ-007 SHALL have port imem_data, input, BITS_SIZE bits, the memory word at imem_addr in the same cycle.
REQ-008 SHALL have port branch_valid, input, 1 bit, the redirect request.
REQ-009 SHALL have port branch_target, input, BITS_SIZE bits, the redirect word index.
REQ-010 SHALL have port halt_req, input, 1 bit, the request to stop fetching.
REQ-011 SHALL have port instr_valid, output, 1 bit, marking the output register as holding an instruction.
REQ-012 SHALL have port instr_ready, input, 1 bit, the consumer accept.
REQ-013 SHALL have port instr, output, BITS_SIZE bits, the issued instruction.
REQ-014 SHALL have port instr_pc, output, BITS_SIZE bits, the word index of instr.
REQ-015 SHALL have port halted, output, 1 bit, high while in HALT.
REQ-016 SHALL have port issued_count, output, BITS_SIZE bits, the count of accepted instructions.
REQ-017 SHALL have port fault, output, 1 bit, the out-of-range trap flag; it exists only under the macro in REQ-031.

Function
REQ-018 SHALL drive imem_addr combinationally from internal register pc.
REQ-019 SHALL implement states IDLE, FETCH and HALT, plus FAULT under the macro; IDLE SHALL go to FETCH unconditionally after one cycle.
REQ-020 In FETCH, when instr_valid is 0 or instr_ready is 1 (slot free), the block SHALL load instr <= imem_data and instr_pc <= pc, set instr_valid <= 1, and set pc <= pc+1.
REQ-021 When instr_valid=1 and instr_ready=0, the block SHALL hold instr, instr_pc, instr_valid and pc unchanged (no drop, no duplicate).
REQ-022 On valid&ready, issued_count SHALL increment by 1, modulo 2^BITS_SIZE.
REQ-023 branch_valid in FETCH SHALL take priority over REQ-020: pc <= branch_target and instr_valid <= 0 next cycle; a held instruction is discarded unless accepted in that same cycle, in which case it is counted.
REQ-024 Branch latency: the target instruction SHALL appear with instr_valid=1 exactly 2 cycles after the branch_valid cycle.
REQ-025 halt_req in FETCH SHALL stop new loads; the block SHALL enter HALT once instr_valid is 0 or the current instruction is accepted.
REQ-026 If branch_valid and halt_req occur in the same cycle, the branch SHALL update pc, the output SHALL be flushed, and the block SHALL enter HALT next cycle.
REQ-027 HALT SHALL be exited only by reset; branch_valid SHALL be ignored in HALT, IDLE and FAULT.
REQ-028 Without the macro, pc SHALL wrap from MEMORY_SIZE-1 to 0.

Reset
REQ-029 reset SHALL put the block in IDLE with pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, issued_count=0 and fault=0, on the next edge regardless of state.
REQ-030 Reset SHALL take priority over every other input, and the first instr_valid=1 SHALL occur 2 cycles after reset deasserts.

Configuration
REQ-031 Macro FETCH_BOUNDS_CHECK_EN SHALL control range checking: when defined, an increment past MEMORY_SIZE-1 or a branch_target >= MEMORY_SIZE SHALL enter FAULT instead of loading, with fault=1, instr_valid=0, pc held and exit only by reset; when undefined, the fault port and FAULT state SHALL be absent, pc SHALL wrap, and out-of-range branch targets SHALL be reduced modulo MEMORY_SIZE.

Structure
REQ-032 The state enumeration and the defaults for BITS_SIZE and MEMORY_SIZE SHALL live in shared package cpu_pkg.
REQ-033 The output register/handshake slot SHALL be sub-module fetch_slot (load, hold, flush); the next-pc logic and state machine SHALL stay in fetch_controller.

Verification
REQ-034 Streaming: reset, then instr_ready=1 held, memory[i]=i+0x100 -> instr = 0x100, 0x101, 0x102 on consecutive cycles from cycle 2; issued_count=3 after 3 accepts.
REQ-035 Backpressure: instr_ready=0 for 4 cycles on instr_pc=5 -> instr, instr_pc and pc are stable; on release, 5 is accepted once, then 6 follows.
REQ-036 Branch: branch_valid with branch_target=0x40 while instr_pc=3 is held -> instr_valid=0 next cycle, then instr_pc=0x40 two cycles after the branch, and no count for instr_pc=3.
REQ-037 Halt collisions: halt_req with instr_ready=0 -> halted only after acceptance; halt_req together with branch_valid -> HALT and a flushed output.
REQ-038 Wrap/fault: pc=255 with MEMORY_SIZE=256 -> next instr_pc=0 without the macro; with FETCH_BOUNDS_CHECK_EN defined -> fault=1 and instr_valid=0; branch_target=300 -> fault.
REQ-039 Reset mid-stream: reset while instr_valid=1 and count=7 -> next cycle instr_valid=0, count=0, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch front-end types and parameter defaults.
// Defining FETCH_BOUNDS_CHECK_EN adds the FAULT state used by range checking.
package cpu_pkg;

  localparam int DEFAULT_BITS_SIZE   = 32;
  localparam int DEFAULT_MEMORY_SIZE = 256;

`ifdef FETCH_BOUNDS_CHECK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;
`endif

endpackage

// File: rtl/fetch_slot.sv
// Single-entry output register for the fetch stage: load, hold or flush.
module fetch_slot
  import cpu_pkg::*;
#(
  parameter int BITS_SIZE = DEFAULT_BITS_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 flush,
  input  logic [BITS_SIZE-1:0] data,
  input  logic [BITS_SIZE-1:0] pc,
  output logic                 valid,
  output logic [BITS_SIZE-1:0] instr,
  output logic [BITS_SIZE-1:0] instr_pc
);

  // Load wins over flush; flush only drops the valid flag, payload is don't-care then.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= data;
      instr_pc <= pc;
    end else if (flush) begin
      valid    <= 1'b0;
    end else begin
      valid    <= valid;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: next-pc logic, IDLE/FETCH/HALT state machine, issue counter.
// Defining FETCH_BOUNDS_CHECK_EN traps out-of-range fetches into FAULT instead of wrapping.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter int BITS_SIZE   = DEFAULT_BITS_SIZE,
  parameter int MEMORY_SIZE = DEFAULT_MEMORY_SIZE,
  parameter int RESET_PC    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [BITS_SIZE-1:0] imem_addr,
  input  logic [BITS_SIZE-1:0] imem_data,
  input  logic                 branch_valid,
  input  logic [BITS_SIZE-1:0] branch_target,
  input  logic                 halt_req,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [BITS_SIZE-1:0] instr,
  output logic [BITS_SIZE-1:0] instr_pc,
  output logic                 halted,
  output logic [BITS_SIZE-1:0] issued_count
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic                 fault
`endif
);

  localparam logic [BITS_SIZE-1:0] MEM_WORDS = BITS_SIZE'(MEMORY_SIZE);
  localparam logic [BITS_SIZE-1:0] LAST_WORD = BITS_SIZE'(MEMORY_SIZE - 1);
  localparam logic [BITS_SIZE-1:0] ONE       = BITS_SIZE'(1);

  fetch_state_t         state_r;
  fetch_state_t         state_next_s;
  logic [BITS_SIZE-1:0] pc_r;
  logic [BITS_SIZE-1:0] pc_next_s;
  logic [BITS_SIZE-1:0] count_r;
  logic                 halted_r;
  logic                 halt_pend_r;
  logic                 halt_pend_next_s;
  logic                 load_s;
  logic                 flush_s;
  logic                 slot_valid_s;
  logic                 slot_free_s;
  logic                 accept_s;
  logic                 halt_eff_s;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic                 fault_r;
  logic                 fault_next_s;
`else
  function automatic logic [BITS_SIZE-1:0] next_word(input logic [BITS_SIZE-1:0] p);
    return (p >= LAST_WORD) ? '0 : p + ONE;
  endfunction
`endif

  assign imem_addr    = pc_r;
  assign instr_valid  = slot_valid_s;
  assign halted       = halted_r;
  assign issued_count = count_r;
  assign slot_free_s  = ~slot_valid_s | instr_ready;
  assign accept_s     = slot_valid_s & instr_ready;
  // A one-cycle halt_req pulse is remembered until the held instruction drains.
  assign halt_eff_s   = halt_req | halt_pend_r;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign fault        = fault_r;
`endif

  fetch_slot #(.BITS_SIZE(BITS_SIZE)) u_slot (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .flush    (flush_s),
    .data     (imem_data),
    .pc       (pc_r),
    .valid    (slot_valid_s),
    .instr    (instr),
    .instr_pc (instr_pc)
  );

  // Next-state, next-pc and slot control; branch beats halt beats sequential load.
  always_comb begin
    state_next_s     = state_r;
    pc_next_s        = pc_r;
    halt_pend_next_s = halt_pend_r;
    load_s           = 1'b0;
    flush_s          = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_next_s     = fault_r;
`endif
    case (state_r)
      IDLE: begin
        state_next_s = FETCH;
      end
      FETCH: begin
        if (branch_valid) begin
          flush_s = 1'b1;
`ifdef FETCH_BOUNDS_CHECK_EN
          if (branch_target >= MEM_WORDS) begin
            state_next_s = FAULT;
            fault_next_s = 1'b1;
          end else begin
            pc_next_s    = branch_target;
            state_next_s = halt_eff_s ? HALT : FETCH;
          end
`else
          pc_next_s    = branch_target % MEM_WORDS;
          state_next_s = halt_eff_s ? HALT : FETCH;
`endif
        end else if (halt_eff_s) begin
          halt_pend_next_s = 1'b1;
          if (slot_free_s) begin
            state_next_s = HALT;
            flush_s      = 1'b1;
          end else begin
            state_next_s = FETCH;
          end
        end else if (slot_free_s) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          if (pc_r >= LAST_WORD) begin
            state_next_s = FAULT;
            fault_next_s = 1'b1;
            flush_s      = 1'b1;
          end else begin
            load_s    = 1'b1;
            pc_next_s = pc_r + ONE;
          end
`else
          load_s    = 1'b1;
          pc_next_s = next_word(pc_r);
`endif
        end else begin
          load_s = 1'b0;
        end
      end
      HALT: begin
        state_next_s = HALT;
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      FAULT: begin
        state_next_s = FAULT;
      end
`endif
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, pc, status flags and the accepted-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      pc_r        <= BITS_SIZE'(RESET_PC);
      halt_pend_r <= 1'b0;
      halted_r    <= 1'b0;
      count_r     <= '0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_r     <= 1'b0;
`endif
    end else begin
      state_r     <= state_next_s;
      pc_r        <= pc_next_s;
      halt_pend_r <= halt_pend_next_s;
      halted_r    <= (state_next_s == HALT);
      count_r     <= count_r + {{(BITS_SIZE-1){1'b0}}, accept_s};
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_r     <= fault_next_s;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: expected accepts queued by stimulus, popped by a monitor.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_valid;
  logic        halt_req;
  logic        instr_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] issued_count;
  logic        instr_valid;
  logic        halted;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        fault;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  // memory[i] = i + 0x100 for the 256 valid words
  assign imem_data = (imem_addr < 32'd256) ? (imem_addr + 32'h100) : 32'h0;

  fetch_controller dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .halted        (halted),
    .issued_count  (issued_count)
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    .fault         (fault)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    logic [31:0] word;
    word = pc + 32'h100;
    exp_q.push_back({pc, word});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every accepted handshake must match the next queued expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL accept_unexpected: got pc %h instr %h, required no accept", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          errors++;
          $display("FAIL accept_order: got pc %h instr %h, required pc %h instr %h",
                   instr_pc, instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; branch_valid = 1'b0; branch_target = 32'h0; halt_req = 1'b0; instr_ready = 1'b0;
    tick(2);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_count", issued_count, 32'h0);
    check("rst_pc", imem_addr, 32'h0);
`ifdef FETCH_BOUNDS_CHECK_EN
    check("rst_fault", {31'h0, fault}, 32'h0);
`endif

    // Streaming, then backpressure on instr_pc=5, then reset mid-stream at count 7
    for (int i = 0; i < 7; i++) push(i);
    reset = 1'b0; instr_ready = 1'b1;
    tick(1);
    check("idle_no_valid", {31'h0, instr_valid}, 32'h0);
    tick(1);
    check("first_valid", {31'h0, instr_valid}, 32'h1);
    check("first_instr", instr, 32'h100);
    tick(3);
    check("stream_count", issued_count, 32'd3);
    check("stream_pc", instr_pc, 32'd3);
    tick(2);
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("bp_instr_pc", instr_pc, 32'd5);
      check("bp_instr", instr, 32'h105);
      check("bp_pc", imem_addr, 32'd6);
    end
    check("bp_count", issued_count, 32'd5);
    instr_ready = 1'b1;
    tick(1);
    check("release_pc", instr_pc, 32'd6);
    check("release_count", issued_count, 32'd6);
    tick(1);
    check("pre_rst_count", issued_count, 32'd7);
    check("pre_rst_valid", {31'h0, instr_valid}, 32'h1);
    instr_ready = 1'b0; reset = 1'b1;
    tick(1);
    check("midrst_valid", {31'h0, instr_valid}, 32'h0);
    check("midrst_count", issued_count, 32'h0);
    check("midrst_pc", imem_addr, 32'h0);
    check("queue_a", exp_q.size(), 32'd0);

    // Branch while instr_pc=3 is held; the held instruction must not be counted
    for (int i = 0; i < 3; i++) push(i);
    reset = 1'b0; instr_ready = 1'b1;
    tick(5);
    instr_ready = 1'b0;
    check("br_held_pc", instr_pc, 32'd3);
    branch_valid = 1'b1; branch_target = 32'h40;
    tick(1);
    branch_valid = 1'b0;
    check("br_flush", {31'h0, instr_valid}, 32'h0);
    check("br_pc", imem_addr, 32'h40);
    push(32'h40);
    instr_ready = 1'b1;
    tick(1);
    check("br_target_valid", {31'h0, instr_valid}, 32'h1);
    check("br_target_pc", instr_pc, 32'h40);
    tick(1);
    instr_ready = 1'b0;
    check("br_count", issued_count, 32'd4);

    // Halt with backpressure: HALT only after the held 0x41 is accepted
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    check("halt_wait", {31'h0, halted}, 32'h0);
    check("halt_wait_pc", instr_pc, 32'h41);
    tick(1);
    check("halt_wait2", {31'h0, halted}, 32'h0);
    push(32'h41);
    instr_ready = 1'b1;
    tick(1);
    check("halt_entered", {31'h0, halted}, 32'h1);
    check("halt_valid", {31'h0, instr_valid}, 32'h0);
    check("halt_count", issued_count, 32'd5);
    branch_valid = 1'b1; branch_target = 32'h10;
    tick(2);
    branch_valid = 1'b0;
    check("halt_br_ignored", imem_addr, 32'h42);
    check("halt_stays", {31'h0, halted}, 32'h1);
    check("queue_b", exp_q.size(), 32'd0);

    // halt_req together with branch_valid: flushed output, pc redirected, HALT
    reset = 1'b1; instr_ready = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);
    check("hb_held", instr_pc, 32'h0);
    halt_req = 1'b1; branch_valid = 1'b1; branch_target = 32'h20;
    tick(1);
    halt_req = 1'b0; branch_valid = 1'b0; instr_ready = 1'b1;
    check("hb_halted", {31'h0, halted}, 32'h1);
    check("hb_flush", {31'h0, instr_valid}, 32'h0);
    check("hb_pc", imem_addr, 32'h20);
    tick(2);
    check("hb_count", issued_count, 32'h0);
    check("hb_still_flushed", {31'h0, instr_valid}, 32'h0);

    // End of memory: wrap, or fault when bounds checking is built in
    reset = 1'b1; instr_ready = 1'b0;
    tick(1);
    reset = 1'b0; instr_ready = 1'b1;
    push(32'h0);
    tick(2);
    branch_valid = 1'b1; branch_target = 32'hFE;
    tick(1);
    branch_valid = 1'b0;
    check("edge_br_count", issued_count, 32'd1);
    check("edge_br_pc", imem_addr, 32'hFE);
`ifdef FETCH_BOUNDS_CHECK_EN
    push(32'hFE);
    tick(1);
    check("edge_fe", instr_pc, 32'hFE);
    tick(1);
    check("fault_set", {31'h0, fault}, 32'h1);
    check("fault_valid", {31'h0, instr_valid}, 32'h0);
    check("fault_pc_held", imem_addr, 32'hFF);
    check("fault_count", issued_count, 32'd2);
    reset = 1'b1; instr_ready = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    branch_valid = 1'b1; branch_target = 32'd300;
    tick(1);
    branch_valid = 1'b0;
    check("fault_br", {31'h0, fault}, 32'h1);
    check("fault_br_valid", {31'h0, instr_valid}, 32'h0);
    tick(1);
    check("fault_br_pc", imem_addr, 32'h0);
`else
    push(32'hFE);
    push(32'hFF);
    tick(3);
    instr_ready = 1'b0;
    check("wrap_pc", instr_pc, 32'h0);
    check("wrap_instr", instr, 32'h100);
    check("wrap_count", issued_count, 32'd3);
    branch_valid = 1'b1; branch_target = 32'd300;
    tick(1);
    branch_valid = 1'b0;
    check("br_mod_pc", imem_addr, 32'h2C);
    check("br_mod_flush", {31'h0, instr_valid}, 32'h0);
`endif
    check("queue_end", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
